diffdigota_gate_seq: RTL and testbench
======================================

Name: diffdigota_gate_seq

Overview:
Sequential gate-drive sequencer that sits between the DiffDigota decode logic and the six output-stage transistor gates (cm, om and op legs, each with one PMOS and one NMOS).
It enforces break-before-make dead time per leg, a power-up settle interval after oe, and an orderly shutdown.
It also flags illegal shoot-through requests.
Requests come in with the same polarity as the DiffDigota outputs: PMOS gate active-low, NMOS gate active-high.

Parameters:
DEAD_CYC, 2, minimum both-off cycles per leg is DEAD_CYC+1; range 1..(2^CNT_W)-1
START_CYC, 8, cycles in STARTUP before RUN; must be > DEAD_CYC
CNT_W, 4, width of the dead-time and startup counters

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
oe  in  1  output enable, synchronous to clk
req_cmpmos  in  1  cm leg PMOS request (0 = on)
req_cmnmos  in  1  cm leg NMOS request (1 = on)
req_ompmos  in  1  om leg PMOS request (0 = on)
req_omnmos  in  1  om leg NMOS request (1 = on)
req_oppmos  in  1  op leg PMOS request (0 = on)
req_opnmos  in  1  op leg NMOS request (1 = on)
clr_conflict  in  1  clears the sticky conflict flag
cmpmos, ompmos, oppmos  out  1 each  registered PMOS gate drives (0 = on)
cmnmos, omnmos, opnmos  out  1 each  registered NMOS gate drives (1 = on)
ready  out  1  high only in RUN
conflict  out  1  sticky shoot-through request flag

Behaviour:
- Reset (async, rst_n=0):
  - all *pmos = 1, all *nmos = 0, ready = 0, conflict = 0
  - sequencer in DISABLED; every leg in OFF with cnt = 0
  - reset mid-operation forces these values immediately, without waiting for a clock edge.
- Per-leg target decode from the requests:
  - P only (pmos req 0, nmos req 0) -> P
  - N only (pmos req 1, nmos req 1) -> N
  - neither -> OFF
  - both (pmos req 0, nmos req 1) -> CONFLICT, treated as OFF.
- Leg FSM states:
  - OFF: both gates off.
  - PON: pmos = 0, nmos = 0.
  - NON: pmos = 1, nmos = 1.
- Leg dead-time counter:
  - cnt is set to 0 on entry to OFF.
  - It increments each cycle spent in OFF and saturates at DEAD_CYC.
- Leg transitions, when the sequencer is in RUN:
  - OFF -> PON if target P and cnt == DEAD_CYC.
  - OFF -> NON if target N and cnt == DEAD_CYC.
  - PON -> OFF if target != P.
  - NON -> OFF if target != N.
  - There is no direct PON <-> NON transition. Minimum both-off time is DEAD_CYC+1 cycles.
  - Gate outputs are registered from state: a request change is visible one cycle after it is sampled.
- When the sequencer is not in RUN, every leg is forced to OFF (enters next cycle); counters keep counting.
- Sequencer FSM:
  - DISABLED: if oe = 1, go to STARTUP with scnt = 0.
  - STARTUP: legs forced OFF; scnt increments. If oe = 0, go to DISABLED. If scnt == START_CYC-1, go to RUN.
  - RUN: ready = 1 (registered, asserted the cycle the state is RUN). If oe = 0, go to SHUTDOWN.
  - SHUTDOWN: legs forced OFF; ready = 0. When all three leg cnt == DEAD_CYC, go to DISABLED. oe is ignored while in SHUTDOWN.
- Conflict flag:
  - Set on any cycle in RUN where any leg target is CONFLICT.
  - Cleared by clr_conflict; set wins on a simultaneous set and clear.
  - Conflicts outside RUN are ignored.
- Invariant: for each leg, pmos = 0 and nmos = 1 never occur in the same cycle, under any input sequence.

Test Plan:
- Startup: reset, oe = 1 at cycle 0 with cm requesting P -> ready = 0 and cmpmos = 1 for cycles 1..8; ready = 1 at cycle 9; cmpmos = 0 at cycle 10.
- Break-before-make: om in PON, request switches to N at cycle t -> ompmos = 1 at t+1; omnmos = 0 through t+3; omnmos = 1 at t+4 (both off exactly 3 cycles).
- Rapid toggle: op in NON, request goes OFF for 1 cycle then back to N -> opnmos drops for 3 cycles before reasserting, never shorter.
- Conflict: in RUN, cm requests both on -> cm leg OFF next cycle and conflict = 1, held after the request clears; clr_conflict = 1 -> conflict = 0 next cycle; simultaneous set and clear -> conflict stays 1.
- Shutdown: RUN with opnmos = 1, oe drops at t -> all gates off and ready = 0 at t+1; oe re-asserted at t+1 is ignored until DISABLED at t+4; STARTUP follows.
- Async reset: rst_n pulled low mid-RUN between clock edges -> all outputs at reset values immediately; a random-request soak checks the no-overlap invariant every cycle.

Source files
------------

// File: rtl/diffdigota_gate_seq.sv
// Gate-drive sequencer for the DiffDigota output stage: three legs (cm, om, op),
// each with break-before-make dead time, plus power-up settle and orderly shutdown.
module diffdigota_gate_seq #(
    parameter int DEAD_CYC  = 2,
    parameter int START_CYC = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic oe,
    input  logic req_cmpmos,
    input  logic req_cmnmos,
    input  logic req_ompmos,
    input  logic req_omnmos,
    input  logic req_oppmos,
    input  logic req_opnmos,
    input  logic clr_conflict,
    output logic cmpmos,
    output logic ompmos,
    output logic oppmos,
    output logic cmnmos,
    output logic omnmos,
    output logic opnmos,
    output logic ready,
    output logic conflict
);

    typedef enum logic [1:0] {
        SEQ_DISABLED = 2'd0,
        SEQ_STARTUP  = 2'd1,
        SEQ_RUN      = 2'd2,
        SEQ_SHUTDOWN = 2'd3
    } seq_e;

    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_PON = 2'd1,
        LEG_NON = 2'd2
    } leg_e;

    localparam logic [CNT_W-1:0] DEAD_MAX   = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);

    // Leg index 0 = cm, 1 = om, 2 = op.
    logic [2:0] req_p;
    logic [2:0] req_n;
    logic [2:0] leg_pmos;
    logic [2:0] leg_nmos;
    logic [2:0] leg_dead;
    logic [2:0] leg_conflict;
    logic       leg_en;

    seq_e             seq_q, seq_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             ready_q, ready_d;
    logic             conflict_q, conflict_d;

    assign req_p = {req_oppmos, req_ompmos, req_cmpmos};
    assign req_n = {req_opnmos, req_omnmos, req_cmnmos};

    // Legs may only switch on while RUN is both current and next state, so a
    // falling oe forces every gate off on the same edge that leaves RUN.
    assign leg_en = (seq_q == SEQ_RUN) && oe;

    for (genvar g = 0; g < 3; g++) begin : g_leg
        leg_e             state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pmos_q, pmos_d;
        logic             nmos_q, nmos_d;
        logic             want_p, want_n;

        assign want_p = !req_p[g] && !req_n[g];
        assign want_n =  req_p[g] &&  req_n[g];

        // NOTE: every variable gets a default at the top of always_comb, so no
        // path through the case can leave it unassigned and infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                LEG_OFF: begin
                    if (cnt_q < DEAD_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (leg_en && (cnt_q == DEAD_MAX)) begin
                        if (want_p) begin
                            state_d = LEG_PON;
                        end else if (want_n) begin
                            state_d = LEG_NON;
                        end
                    end
                end
                LEG_PON: begin
                    if (!leg_en || !want_p) begin
                        state_d = LEG_OFF;
                        cnt_d   = '0;
                    end
                end
                LEG_NON: begin
                    if (!leg_en || !want_n) begin
                        state_d = LEG_OFF;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LEG_OFF;
                    cnt_d   = '0;
                end
            endcase
            // Gates are decoded from the next state and registered, so the two
            // drives of a leg can never both be on in the same cycle.
            pmos_d = (state_d != LEG_PON);
            nmos_d = (state_d == LEG_NON);
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= LEG_OFF;
                cnt_q   <= '0;
                pmos_q  <= 1'b1;
                nmos_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pmos_q  <= pmos_d;
                nmos_q  <= nmos_d;
            end
        end

        assign leg_pmos[g]     = pmos_q;
        assign leg_nmos[g]     = nmos_q;
        assign leg_dead[g]     = (cnt_q == DEAD_MAX);
        assign leg_conflict[g] = !req_p[g] && req_n[g];
    end

    always_comb begin
        seq_d  = seq_q;
        scnt_d = scnt_q;
        unique case (seq_q)
            SEQ_DISABLED: begin
                if (oe) begin
                    seq_d  = SEQ_STARTUP;
                    scnt_d = '0;
                end
            end
            SEQ_STARTUP: begin
                if (!oe) begin
                    seq_d = SEQ_DISABLED;
                end else if (scnt_q == START_LAST) begin
                    seq_d = SEQ_RUN;
                end else begin
                    scnt_d = scnt_q + CNT_W'(1);
                end
            end
            SEQ_RUN: begin
                if (!oe) begin
                    seq_d = SEQ_SHUTDOWN;
                end
            end
            SEQ_SHUTDOWN: begin
                // oe is deliberately ignored until every leg has drained its dead time.
                if (&leg_dead) begin
                    seq_d = SEQ_DISABLED;
                end
            end
            default: begin
                seq_d = SEQ_DISABLED;
            end
        endcase

        ready_d = (seq_d == SEQ_RUN);

        // A new shoot-through request wins over a clear on the same cycle.
        if ((seq_q == SEQ_RUN) && (|leg_conflict)) begin
            conflict_d = 1'b1;
        end else if (clr_conflict) begin
            conflict_d = 1'b0;
        end else begin
            conflict_d = conflict_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q      <= SEQ_DISABLED;
            scnt_q     <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            scnt_q     <= scnt_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end

    assign cmpmos   = leg_pmos[0];
    assign ompmos   = leg_pmos[1];
    assign oppmos   = leg_pmos[2];
    assign cmnmos   = leg_nmos[0];
    assign omnmos   = leg_nmos[1];
    assign opnmos   = leg_nmos[2];
    assign ready    = ready_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_diffdigota_gate_seq.sv
// Bench for diffdigota_gate_seq: directed vector table, shutdown and async-reset
// sequences, then a random soak against a behavioural model of the sequencer.
module tb_diffdigota_gate_seq;

    localparam int DEAD_CYC  = 2;
    localparam int START_CYC = 8;
    localparam int CNT_W     = 4;

    localparam int PH_DIS = 0;
    localparam int PH_ST  = 1;
    localparam int PH_RUN = 2;
    localparam int PH_SD  = 3;

    // Observation word: {op,om,cm pmos, op,om,cm nmos, ready, conflict}.
    localparam logic [7:0] RESET_OBS = 8'b111_000_0_0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       oe = 1'b0;
    logic       clr_conflict = 1'b0;
    logic [2:0] rp = 3'b111;
    logic [2:0] rn = 3'b000;
    logic cmpmos, ompmos, oppmos, cmnmos, omnmos, opnmos, ready, conflict;

    int n_vec = 0;
    int n_bad = 0;

    diffdigota_gate_seq #(
        .DEAD_CYC (DEAD_CYC),
        .START_CYC(START_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .oe          (oe),
        .req_cmpmos  (rp[0]),
        .req_cmnmos  (rn[0]),
        .req_ompmos  (rp[1]),
        .req_omnmos  (rn[1]),
        .req_oppmos  (rp[2]),
        .req_opnmos  (rn[2]),
        .clr_conflict(clr_conflict),
        .cmpmos      (cmpmos),
        .ompmos      (ompmos),
        .oppmos      (oppmos),
        .cmnmos      (cmnmos),
        .omnmos      (omnmos),
        .opnmos      (opnmos),
        .ready       (ready),
        .conflict    (conflict)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic       oe;
        logic [2:0] rp;
        logic [2:0] rn;
        logic       clr;
        logic [2:0] ep;
        logic [2:0] en;
        logic       er;
        logic       ec;
    } vec_t;

    vec_t tbl [24];

    // Behavioural model: per-leg mode (0 off, 1 P, 2 N) with cycles spent off,
    // sequencer phase with cycles spent in startup.
    int m_mode [3];
    int m_off  [3];
    int m_phase;
    int m_st;
    bit m_conf;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0;
            m_off[i]  = 0;
        end
        m_phase = PH_DIS;
        m_st    = 0;
        m_conf  = 1'b0;
    endfunction

    function automatic int target(input logic p, input logic n);
        if (!p && !n) return 1;
        if (p && n) return 2;
        if (!p && n) return 3;
        return 0;
    endfunction

    function automatic void model_step(input logic oe_s, input logic [2:0] rp_s,
                                       input logic [2:0] rn_s, input logic clr_s);
        bit en;
        bit settled;
        bit any_conf;
        int t;
        en       = (m_phase == PH_RUN) && oe_s;
        settled  = 1'b1;
        any_conf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_mode[i] != 0 || m_off[i] < DEAD_CYC) settled = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            t = target(rp_s[i], rn_s[i]);
            if (t == 3) any_conf = 1'b1;
            if (m_mode[i] == 0) begin
                if (en && m_off[i] >= DEAD_CYC && (t == 1 || t == 2)) m_mode[i] = t;
                else m_off[i] = m_off[i] + 1;
            end else if (!en || t != m_mode[i]) begin
                m_mode[i] = 0;
                m_off[i]  = 0;
            end
        end
        m_conf = ((m_phase == PH_RUN) && any_conf) || (m_conf && !clr_s);
        case (m_phase)
            PH_DIS: if (oe_s) begin m_phase = PH_ST; m_st = 0; end
            PH_ST: begin
                if (!oe_s) m_phase = PH_DIS;
                else begin
                    m_st = m_st + 1;
                    if (m_st == START_CYC) m_phase = PH_RUN;
                end
            end
            PH_RUN: if (!oe_s) m_phase = PH_SD;
            default: if (settled) m_phase = PH_DIS;
        endcase
    endfunction

    function automatic logic [7:0] model_obs();
        logic [2:0] p;
        logic [2:0] n;
        for (int i = 0; i < 3; i++) begin
            p[i] = (m_mode[i] != 1);
            n[i] = (m_mode[i] == 2);
        end
        return {p, n, (m_phase == PH_RUN), m_conf};
    endfunction

    function automatic logic [7:0] obs();
        return {oppmos, ompmos, cmpmos, opnmos, omnmos, cmnmos, ready, conflict};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_pulse(input string name);
        #2 rst_n = 1'b0;
        #1 check(name, obs(), RESET_OBS);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Startup with cm/om asking for P and op for N, then om P->N, op toggle, cm conflict.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 3'b100, 3'b100, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'b100, 3'b100, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 3'b100, 3'b100, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b100, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b100, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b100, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b110, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 3'b110, 3'b010, 1'b0, 3'b110, 3'b010, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b010, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b010, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b110, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 3'b110, 3'b111, 1'b0, 3'b111, 3'b110, 1'b1, 1'b1};
        tbl[19] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b111, 3'b110, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 3'b110, 3'b110, 1'b1, 3'b111, 3'b110, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 3'b110, 3'b110, 1'b0, 3'b110, 3'b110, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 3'b110, 3'b111, 1'b1, 3'b111, 3'b110, 1'b1, 1'b1};
        tbl[23] = '{1'b1, 3'b110, 3'b110, 1'b1, 3'b111, 3'b110, 1'b1, 1'b0};

        #12;
        check("reset_state", obs(), RESET_OBS);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            oe           = tbl[i].oe;
            rp           = tbl[i].rp;
            rn           = tbl[i].rn;
            clr_conflict = tbl[i].clr;
            step();
            check($sformatf("vec%0d", i + 1), obs(),
                  {tbl[i].ep, tbl[i].en, tbl[i].er, tbl[i].ec});
        end

        // Shutdown: oe drops, re-asserted one cycle later; a conflict request
        // during shutdown/startup must be ignored. RUN returns 12 edges later.
        oe           = 1'b0;
        rp           = 3'b110;
        rn           = 3'b110;
        clr_conflict = 1'b0;
        step();
        check("shutdown_off", obs(), RESET_OBS);
        oe = 1'b1;
        rn = 3'b111;
        for (int k = 2; k <= 12; k++) begin
            step();
            check($sformatf("shutdown_wait%0d", k), obs(), RESET_OBS);
            if (k == 8) rn = 3'b110;
        end
        step();
        check("restart_ready", obs(), 8'b111_000_1_0);
        step();
        check("restart_gates", obs(), 8'b110_110_1_0);

        // Async reset between edges while running.
        async_reset_pulse("async_reset_mid_run");
        oe = 1'b0;
        rp = 3'b111;
        rn = 3'b000;
        step();
        check("after_reset_release", obs(), RESET_OBS);

        // Random soak against the model; occasional mid-run async resets.
        model_reset();
        async_reset_pulse("soak_reset");
        oe = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] pick;
            if ($urandom_range(59) == 0) oe = ~oe;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(99) < 25) begin
                    pick  = 2'($urandom_range(3));
                    rp[i] = pick[1];
                    rn[i] = pick[0];
                end
            end
            clr_conflict = ($urandom_range(9) == 0);
            step();
            model_step(oe, rp, rn, clr_conflict);
            check($sformatf("soak%0d", c), obs(), model_obs());
            check($sformatf("overlap%0d", c),
                  {5'b00000, {oppmos, ompmos, cmpmos} == 3'b000 ? 3'b000 :
                              (~{oppmos, ompmos, cmpmos} & {opnmos, omnmos, cmnmos})},
                  8'h00);
            if ($urandom_range(499) == 0) begin
                model_reset();
                async_reset_pulse($sformatf("soak_async%0d", c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
